// File: rtl/wdt_reset_gen.sv
// wdt_reset_gen: turns watchdog bites and software reset requests into a
// stretched, ce-timed board reset pulse followed by a quiet hold-off window.
// A sticky reset-cause register lets software see why the board was reset.
// rst is the power-on reset only; reset_out must never feed back into it,
// otherwise the cause register would be wiped by the pulse it explains.
module wdt_reset_gen #(
  parameter logic [4:0] BASE_ADDR     = 5'h0,
  parameter logic [7:0] PULSE_TICKS   = 8'd20,
  parameter logic [7:0] HOLDOFF_TICKS = 8'd10,
  parameter logic [7:0] SRST_KEY      = 8'ha5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic [1:0] wdt_out_strobe,
  input  logic       force_recovery_mode,
  output logic       reset_out,
  output logic       recovery_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [4:0] ADDR_CAUSE = BASE_ADDR;
  localparam logic [4:0] ADDR_SRST  = BASE_ADDR + 5'd1;
  localparam logic [4:0] ADDR_STAT  = BASE_ADDR + 5'd2;

  state_t     r_state, w_nextState;
  logic [7:0] r_cnt, w_nextCnt;
  logic       r_pending, w_nextPending;
  logic       r_recPend, w_nextRecPend;
  logic       r_rec, w_nextRec;
  logic [3:0] r_cause, w_nextCause;
  logic       r_resetOut, r_recoveryOut, r_busy;
  logic       w_nextResetOut, w_nextRecoveryOut, w_nextBusy;
  logic       w_reqW0, w_reqW1, w_reqSw, w_req;
  logic [3:0] w_causeClr, w_causeSet;

  assign w_reqW0 = wdt_out_strobe[0];
  assign w_reqW1 = wdt_out_strobe[1];
  assign w_reqSw = csr_we & (csr_a == ADDR_SRST) & (csr_di == SRST_KEY);
  assign w_req   = w_reqW0 | w_reqW1 | w_reqSw;

  assign reset_out    = r_resetOut;
  assign recovery_out = r_recoveryOut;
  assign busy         = r_busy;

  // State register plus the outputs, which are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_pending     <= 1'b0;
      r_recPend     <= 1'b0;
      r_rec         <= 1'b0;
      r_cause       <= 4'd0;
      r_resetOut    <= 1'b0;
      r_recoveryOut <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_cnt         <= w_nextCnt;
      r_pending     <= w_nextPending;
      r_recPend     <= w_nextRecPend;
      r_rec         <= w_nextRec;
      r_cause       <= w_nextCause;
      r_resetOut    <= w_nextResetOut;
      r_recoveryOut <= w_nextRecoveryOut;
      r_busy        <= w_nextBusy;
    end
  end

  // Next-state logic: pulse and hold-off counters step only on ce, and end at cnt==1
  always_comb begin
    w_nextState   = r_state;
    w_nextCnt     = r_cnt;
    w_nextPending = r_pending;
    w_nextRecPend = r_recPend;
    w_nextRec     = r_rec;
    case (r_state)
      ST_IDLE: begin
        if (w_req || r_pending) begin
          w_nextState   = ST_ASSERT;
          w_nextCnt     = PULSE_TICKS;
          w_nextPending = 1'b0;
          w_nextRecPend = 1'b0;
          w_nextRec     = force_recovery_mode | r_recPend;
        end
      end
      ST_ASSERT: begin
        if (ce) begin
          if (r_cnt == 8'd1) begin
            w_nextState = ST_HOLDOFF;
            w_nextCnt   = HOLDOFF_TICKS;
          end else begin
            w_nextCnt = r_cnt - 8'd1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (ce) begin
          if (r_cnt == 8'd1) begin
            w_nextState = ST_IDLE;
            w_nextRec   = 1'b0;
          end else begin
            w_nextCnt = r_cnt - 8'd1;
          end
        end
        if (w_req) begin
          w_nextPending = 1'b1;
          if (force_recovery_mode) w_nextRecPend = 1'b1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCnt   = 8'd0;
        w_nextRec   = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it
  always_comb begin
    w_nextResetOut    = (w_nextState == ST_ASSERT);
    w_nextBusy        = (w_nextState != ST_IDLE);
    w_nextRecoveryOut = (w_nextState != ST_IDLE) & w_nextRec;
  end

  // Sticky cause bits: write-1-to-clear, a same-cycle set beats the clear
  always_comb begin
    w_causeClr  = (csr_we && (csr_a == ADDR_CAUSE)) ? csr_di[3:0] : 4'd0;
    w_causeSet  = {w_req & force_recovery_mode, w_reqSw, w_reqW1, w_reqW0};
    w_nextCause = (r_cause & ~w_causeClr) | w_causeSet;
  end

  // Combinational CSR read mux; the soft-reset register is write-only
  always_comb begin
    csr_do = 8'd0;
    if (csr_a == ADDR_CAUSE) begin
      csr_do = {4'd0, r_cause};
    end else if (csr_a == ADDR_STAT) begin
      csr_do = {r_busy, r_pending, 4'd0, r_state};
    end
  end

endmodule

// File: tb/tb_wdt_reset_gen.sv
// tb_wdt_reset_gen: directed bench for wdt_reset_gen. Each expected pulse is
// queued (with its expected recovery qualifier) when the triggering stimulus
// is driven; a per-clock monitor measures pulse and hold-off lengths in ce
// ticks and pops/compares the queue entry when the pulse completes.
module tb_wdt_reset_gen;

  localparam logic [4:0] BASE       = 5'h4;
  localparam logic [4:0] ADDR_CAUSE = BASE;
  localparam logic [4:0] ADDR_SRST  = BASE + 5'd1;
  localparam logic [4:0] ADDR_STAT  = BASE + 5'd2;
  localparam int PULSE = 3;
  localparam int HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'd0;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  logic [1:0] wdt_out_strobe = 2'b00;
  logic       force_recovery_mode = 1'b0;
  logic       reset_out, recovery_out, busy;

  int checkCount = 0;
  int passCount = 0;
  int failCount = 0;
  int cyc = 0;
  int aTicks = 0;
  int hTicks = 0;
  bit monOn = 1'b0;
  bit recQ[$];
  logic [7:0] rd;

  wdt_reset_gen #(
    .BASE_ADDR(BASE),
    .PULSE_TICKS(8'd3),
    .HOLDOFF_TICKS(8'd2),
    .SRST_KEY(8'ha5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .csr_a(csr_a),
    .csr_di(csr_di),
    .csr_we(csr_we),
    .csr_do(csr_do),
    .wdt_out_strobe(wdt_out_strobe),
    .force_recovery_mode(force_recovery_mode),
    .reset_out(reset_out),
    .recovery_out(recovery_out),
    .busy(busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitorStep(input logic prevR, input logic prevB, input logic ceA);
    if (prevR && ceA) aTicks++;
    if (!prevR && prevB && ceA) hTicks++;
    if (!prevB && busy) begin
      check("pulse_expected", 32'(recQ.size() != 0), 1);
      check("reset_first_clk", reset_out, 1);
      aTicks = 0;
      hTicks = 0;
    end
    if (prevR && !reset_out) check("busy_in_holdoff", busy, 1);
    if (busy && recQ.size() != 0) check("recovery_out", recovery_out, recQ[0]);
    if (!busy) check("idle_outputs", {reset_out, recovery_out}, 0);
    if (prevB && !busy) begin
      check("pulse_ticks", aTicks, PULSE);
      check("holdoff_ticks", hTicks, HOLD);
      if (recQ.size() != 0) void'(recQ.pop_front());
    end
  endtask

  task automatic stepClk();
    logic prevR, prevB, ceA;
    ce = (cyc % 4 == 0);
    cyc++;
    prevR = reset_out;
    prevB = busy;
    ceA = ce;
    @(posedge clk);
    #1;
    if (monOn) monitorStep(prevR, prevB, ceA);
  endtask

  task automatic applyStimulus(input logic [1:0] strobe, input logic frm);
    wdt_out_strobe = strobe;
    force_recovery_mode = frm;
    stepClk();
    wdt_out_strobe = 2'b00;
    force_recovery_mode = 1'b0;
  endtask

  task automatic writeCsr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a;
    csr_di = d;
    csr_we = 1'b1;
    stepClk();
    csr_we = 1'b0;
    csr_di = 8'd0;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    rd = csr_do;
    check(tag, rd, exp);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      stepClk();
    end
    check("idle_timeout", busy, 0);
  endtask

  // Linear sequence of directed steps
  initial begin
    $display("[TB] start");
    stepClk();
    stepClk();
    check("rst_reset_out", reset_out, 0);
    check("rst_busy", busy, 0);
    check("rst_recovery_out", recovery_out, 0);
    checkOutput("rst_cause", ADDR_CAUSE, 8'h00);
    checkOutput("rst_stat", ADDR_STAT, 8'h00);
    rst = 1'b0;
    monOn = 1'b1;
    stepClk();

    // 1: w0 bite, no recovery
    recQ.push_back(1'b0);
    applyStimulus(2'b01, 1'b0);
    check("t1_busy", busy, 1);
    checkOutput("t1_cause", ADDR_CAUSE, 8'h01);
    checkOutput("t1_stat", ADDR_STAT, 8'h81);
    waitIdle();
    checkOutput("t1_stat_idle", ADDR_STAT, 8'h00);
    writeCsr(ADDR_CAUSE, 8'h01);
    checkOutput("t1_cause_clr", ADDR_CAUSE, 8'h00);

    // 2: w1 bite with recovery requested
    recQ.push_back(1'b1);
    applyStimulus(2'b10, 1'b1);
    checkOutput("t2_cause", ADDR_CAUSE, 8'h0a);
    waitIdle();
    check("t2_rec_idle", recovery_out, 0);

    // 3: software reset with the right key, then a wrong key
    writeCsr(ADDR_CAUSE, 8'h0f);
    checkOutput("t3_cause_clr", ADDR_CAUSE, 8'h00);
    recQ.push_back(1'b0);
    writeCsr(ADDR_SRST, 8'ha5);
    check("t3_busy", busy, 1);
    checkOutput("t3_cause", ADDR_CAUSE, 8'h04);
    waitIdle();
    writeCsr(ADDR_SRST, 8'h5a);
    stepClk();
    stepClk();
    check("t3_badkey_busy", busy, 0);
    checkOutput("t3_badkey_cause", ADDR_CAUSE, 8'h04);
    checkOutput("t3_srst_read", ADDR_SRST, 8'h00);
    checkOutput("t3_other_read", BASE + 5'd3, 8'h00);
    checkOutput("t3_below_base_read", 5'd0, 8'h00);

    // 4: bite during ASSERT is absorbed; bite during HOLDOFF re-fires
    writeCsr(ADDR_CAUSE, 8'h0f);
    recQ.push_back(1'b0);
    applyStimulus(2'b01, 1'b0);
    stepClk();
    stepClk();
    applyStimulus(2'b10, 1'b0);
    checkOutput("t4_cause", ADDR_CAUSE, 8'h03);
    checkOutput("t4_stat_assert", ADDR_STAT, 8'h81);
    for (int i = 0; i < 200; i++) begin
      if (!reset_out) break;
      stepClk();
    end
    check("t4_assert_timeout", reset_out, 0);
    recQ.push_back(1'b0);
    applyStimulus(2'b01, 1'b0);
    checkOutput("t4_stat_pending", ADDR_STAT, 8'hc2);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      stepClk();
    end
    check("t4_idle_gap", busy, 0);
    checkOutput("t4_stat_idle_pending", ADDR_STAT, 8'h40);
    stepClk();
    check("t4_refire_busy", busy, 1);
    check("t4_refire_reset", reset_out, 1);
    waitIdle();

    // 5: clear and set of bit0 in the same clk, then clear all while quiet
    recQ.push_back(1'b0);
    csr_a = ADDR_CAUSE;
    csr_di = 8'h01;
    csr_we = 1'b1;
    applyStimulus(2'b01, 1'b0);
    csr_we = 1'b0;
    csr_di = 8'h00;
    checkOutput("t5_set_wins", ADDR_CAUSE, 8'h03);
    waitIdle();
    writeCsr(ADDR_CAUSE, 8'h0f);
    checkOutput("t5_cause_clr", ADDR_CAUSE, 8'h00);

    // 6: asynchronous reset in the middle of a pulse
    recQ.push_back(1'b1);
    applyStimulus(2'b10, 1'b1);
    stepClk();
    stepClk();
    check("t6_pre_reset", reset_out, 1);
    check("t6_pre_rec", recovery_out, 1);
    #3;
    monOn = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_async_reset_out", reset_out, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_rec", recovery_out, 0);
    recQ.delete();
    stepClk();
    stepClk();
    rst = 1'b0;
    checkOutput("t6_cause", ADDR_CAUSE, 8'h00);
    checkOutput("t6_stat", ADDR_STAT, 8'h00);

    check("queue_empty", recQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wdt_reset_gen.md
Name: wdt_reset_gen

Overview:
Sits directly downstream of the watchdog block. Consumes its per-output bite strobes and recovery request, and turns each event into a stretched, ce-timed reset pulse with a hold-off window. Also accepts a software reset request over the CSR bus. Latches a sticky reset-cause register that software can read.

Parameters:
BASE_ADDR, 5'h0, CSR base address of this block's registers
PULSE_TICKS, 8'd20, reset_out assertion length in ce ticks; must be >= 1
HOLDOFF_TICKS, 8'd10, post-pulse quiet window in ce ticks; must be >= 1
SRST_KEY, 8'ha5, value whose write to R_SRST requests a soft reset

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
ce  input  1  timebase tick, one-clk pulse
csr_a  input  5  CSR address
csr_di  input  8  CSR write data
csr_we  input  1  CSR write strobe
csr_do  output  8  CSR read data, combinational
wdt_out_strobe  input  2  one-clk bite pulses from the watchdog, one per output
force_recovery_mode  input  1  level from the watchdog, sampled at trigger
reset_out  output  1  registered reset request to the board, active-high
recovery_out  output  1  registered, boot-into-recovery qualifier
busy  output  1  registered, high when the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high: state=IDLE, cnt=0, cause=0, pending=0, rec=0. reset_out=0, recovery_out=0, busy=0.
- Request sources, evaluated each clk:
  - req_w0 = wdt_out_strobe[0]
  - req_w1 = wdt_out_strobe[1]
  - req_sw = csr_we & (csr_a==BASE_ADDR+1) & (csr_di==SRST_KEY)
  - req = any of the above.
- Registers:
  - R_CAUSE (BASE+0): {4'b0, rec_seen, sw, w1, w0}.
    - Read returns the register.
    - Write is write-1-to-clear, per bit.
    - A set event in the same clk as a clear of that bit: the set wins.
  - R_SRST (BASE+1): write-only; reads 0.
  - R_STAT (BASE+2): {busy, pending, 4'b0, state[1:0]}.
  - Any other address reads 0.
- Cause bits are sticky. They set on the clk the corresponding req is seen, in any state. rec_seen sets when req & force_recovery_mode.
- State encoding: IDLE=0, ASSERT=1, HOLDOFF=2.
- IDLE:
  - If req or pending: go to ASSERT, cnt<=PULSE_TICKS, pending<=0, rec<=force_recovery_mode | rec_pend.
  - Otherwise stay in IDLE.
- ASSERT:
  - reset_out=1 (registered, so high from the first clk in ASSERT).
  - On ce: if cnt==1, go to HOLDOFF and cnt<=HOLDOFF_TICKS; else cnt<=cnt-1.
  - Without ce, cnt holds.
  - req during ASSERT: cause is updated; no retrigger and no pending set, because it is absorbed by the current pulse.
- HOLDOFF:
  - reset_out=0. recovery_out stays high if rec.
  - On ce: if cnt==1, go to IDLE and clear rec; else cnt<=cnt-1.
  - req during HOLDOFF: pending<=1. rec_pend<=1 if force_recovery_mode at that clk. Causes a fresh pulse on the clk after re-entering IDLE.
- recovery_out = rec while state!=IDLE. busy = state!=IDLE. Both are registered with the state.
- Pulse width is exactly PULSE_TICKS ce ticks. The first tick counts only if it arrives after ASSERT entry. Hold-off is likewise exactly HOLDOFF_TICKS ticks.
- cnt is 8 bits. It never wraps because transitions fire at cnt==1.
- The block's own reset_out must not be looped back into rst. rst is the power-on reset only, so causes survive the pulse.
- Illegal state (3): next state is IDLE, cnt=0.

Test Plan:
1. PULSE_TICKS=3, HOLDOFF_TICKS=2, ce every 4 clk. Pulse wdt_out_strobe=2'b01 → R_CAUSE=8'h01, reset_out high for exactly 3 ce ticks, busy low after 2 further ticks, recovery_out stays 0.
2. wdt_out_strobe=2'b10 with force_recovery_mode=1 → R_CAUSE=8'h0a, recovery_out=1 for the whole ASSERT+HOLDOFF, 0 in IDLE.
3. Write 8'ha5 to BASE+1 → pulse starts, R_CAUSE bit2 set. Write 8'h5a → no effect.
4. Strobe during ASSERT → no extra pulse, cause bit set. Strobe during HOLDOFF → R_STAT pending=1, and a second full pulse follows IDLE by 1 clk.
5. Write 8'h01 to BASE+0 in the same clk as a new w0 strobe → bit0 remains 1. Write 8'h0f while quiet → R_CAUSE=0.
6. Assert rst mid-ASSERT (async, between clk edges) → reset_out, busy and recovery_out drop immediately; R_CAUSE=0 after release.
